// File: rtl/datamem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package datamem_arbiter_pkg;

  // Access size encoding as carried on rq_size.
  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_BAD = 2'd3
  } size_t;

  // Controller states; explicit encodings keep reset and debug values stable.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/datamem_arbiter_lane_align.sv
// Byte-lane steering for one 32-bit memory word: extracts and extends load
// data, merges sub-word store data into the old word, and flags misalignment.
module datamem_arbiter_lane_align
  import datamem_arbiter_pkg::*;
(
  input  logic [1:0]  offset,
  input  size_t       size,
  input  logic        is_unsigned,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select, extension and read-modify-write merge.
  always_comb begin
    byte_lane = old_word[{offset, 3'b000} +: 8];
    half_lane = old_word[{offset[1], 4'b0000} +: 16];
    merged    = old_word;
    load_data = '0;
    misalign  = 1'b0;
    case (size)
      SZ_B: begin
        load_data = is_unsigned ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
        merged[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        load_data = is_unsigned ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
        merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
        misalign = offset[0];
      end
      SZ_W: begin
        load_data = old_word;
        merged    = wdata;
        misalign  = |offset;
      end
      default: begin
        // Illegal size is rejected by the caller; leave the word untouched.
        merged = old_word;
      end
    endcase
  end

endmodule

// File: rtl/datamem_arbiter.sv
// Two-port round-robin arbiter and access controller for the word-addressed
// data memory. One access per two cycles: grant, ACCESS (memory cycle), RESP.
module datamem_arbiter
  import datamem_arbiter_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MEM_WORDS     = 32'h20000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 rq_valid,
  output logic [1:0]                 rq_ready,
  input  logic [1:0]                 rq_we,
  input  logic [2*ADDRESS_WIDTH-1:0] rq_addr,
  input  logic [3:0]                 rq_size,
  input  logic [1:0]                 rq_unsigned,
  input  logic [2*DATA_WIDTH-1:0]    rq_wdata,
  output logic [1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       rsp_err,
  output logic                       mem_we,
  output logic [ADDRESS_WIDTH-1:0]   mem_a,
  output logic [DATA_WIDTH-1:0]      mem_wd,
  input  logic [DATA_WIDTH-1:0]      mem_rd
);

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("datamem_arbiter supports DATA_WIDTH == 32 only");
  end

  localparam int unsigned OffBits = $clog2(WORD_BYTES);

  state_t                   state_q, state_d;
  logic                     last_grant_q;
  logic                     owner_q;
  logic                     we_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  size_t                    size_q;
  logic                     uns_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    rsp_rdata_q;
  logic                     rsp_err_q;

  logic                     gnt_port;
  logic [1:0]               grant;
  logic                     handshake;
  logic [ADDRESS_WIDTH-1:0] word_idx;
  logic                     out_of_range;
  logic                     misalign;
  logic                     acc_err;
  logic                     in_access;
  logic [DATA_WIDTH-1:0]    merged;
  logic [DATA_WIDTH-1:0]    load_data;

  // Round-robin grant; only offered while no access is in its memory cycle.
  // Ready is masked during reset so nothing is accepted while rst_n is low.
  always_comb begin
    gnt_port = 1'b0;
    grant    = 2'b00;
    if (rst_n && (state_q == IDLE || state_q == RESP)) begin
      case (rq_valid)
        2'b01:   gnt_port = 1'b0;
        2'b10:   gnt_port = 1'b1;
        2'b11:   gnt_port = ~last_grant_q;
        default: gnt_port = 1'b0;
      endcase
      if (|rq_valid) grant = gnt_port ? 2'b10 : 2'b01;
    end
  end

  assign rq_ready  = grant;
  assign handshake = |grant;

  // Next-state: ACCESS always lasts one cycle; RESP may overlap a new grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = handshake ? ACCESS : IDLE;
      ACCESS:  state_d = RESP;
      RESP:    state_d = handshake ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  datamem_arbiter_lane_align u_lane_align (
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .old_word    (mem_rd),
    .wdata       (wdata_q),
    .merged      (merged),
    .load_data   (load_data),
    .misalign    (misalign)
  );

  // Error detection and memory-side drive for the latched request.
  always_comb begin
    word_idx     = addr_q >> OffBits;
    out_of_range = 64'(word_idx) >= 64'(MEM_WORDS);
    acc_err      = (size_q == SZ_BAD) | misalign | out_of_range;
    in_access    = (state_q == ACCESS);
    // Decoded from state so an asynchronous reset kills a store instantly.
    mem_we       = in_access & we_q & ~acc_err;
    mem_wd       = in_access ? merged : '0;
    mem_a        = word_idx;
    rsp_valid    = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    rsp_rdata    = rsp_rdata_q;
    rsp_err      = rsp_err_q;
  end

  // State register and request latch, captured on the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      size_q       <= SZ_B;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        owner_q      <= gnt_port;
        last_grant_q <= gnt_port;
        we_q         <= gnt_port ? rq_we[1] : rq_we[0];
        addr_q       <= gnt_port ? rq_addr[2*ADDRESS_WIDTH-1:ADDRESS_WIDTH]
                                 : rq_addr[ADDRESS_WIDTH-1:0];
        size_q       <= size_t'(gnt_port ? rq_size[3:2] : rq_size[1:0]);
        uns_q        <= gnt_port ? rq_unsigned[1] : rq_unsigned[0];
        wdata_q      <= gnt_port ? rq_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                 : rq_wdata[DATA_WIDTH-1:0];
      end
    end
  end

  // Response registers, loaded at the end of ACCESS and held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (in_access) begin
      rsp_err_q   <= acc_err;
      rsp_rdata_q <= (acc_err || we_q) ? '0 : load_data;
    end
  end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter: per-port request queues drive the DUT, a
// behavioural memory model predicts every response and write, and a negedge
// monitor compares each cycle. Directed literal checks pin the model.
module tb_datamem_arbiter;

  localparam int unsigned MemWords = 32'h20000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rq_valid, rq_ready, rq_we, rq_unsigned, rsp_valid;
  logic [63:0] rq_addr, rq_wdata;
  logic [3:0]  rq_size;
  logic [31:0] rsp_rdata, mem_a, mem_wd, mem_rd;
  logic        rsp_err, mem_we;

  datamem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rq_valid    (rq_valid),
    .rq_ready    (rq_ready),
    .rq_we       (rq_we),
    .rq_addr     (rq_addr),
    .rq_size     (rq_size),
    .rq_unsigned (rq_unsigned),
    .rq_wdata    (rq_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .mem_we      (mem_we),
    .mem_a       (mem_a),
    .mem_wd      (mem_wd),
    .mem_rd      (mem_rd)
  );

  always #5 clk = ~clk;

  // Environment memory (first 1024 words are enough for the tests).
  logic [31:0] dmem [1024];
  assign mem_rd = dmem[mem_a[9:0]];
  always @(posedge clk) if (mem_we) dmem[mem_a[9:0]] <= mem_wd;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int unsigned due;
    int          port;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    int unsigned due;
    logic [31:0] word;
    logic [31:0] data;
  } wr_t;

  req_t        pend0[$], pend1[$];
  req_t        cur0, cur1;
  rsp_t        exp_q[$];
  wr_t         wr_q[$];
  logic [31:0] ref_mem [1024];
  int          nvec, nerr;
  int unsigned cyc;
  int          we_count;
  logic [31:0] last_mem_a;
  int          hs_port[$];
  int unsigned hs_cyc[$];
  logic [31:0] rsp_log[$];
  logic        err_log[$];
  logic [1:0]  hs_flag;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic req_t mk(input logic we, input logic [31:0] addr, input logic [1:0] size,
                              input logic uns, input logic [31:0] wdata);
    req_t r;
    r.we = we; r.addr = addr; r.size = size; r.uns = uns; r.wdata = wdata;
    return r;
  endfunction

  // Model: architectural rules written as plain arithmetic.
  function automatic logic m_err(input logic [31:0] addr, input logic [1:0] size);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
           (size == 2'd2 && addr % 4 != 0) || (addr / 4 >= MemWords);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input int off,
                                         input logic [1:0] size, input logic uns);
    logic [31:0] v;
    v = word >> (8 * off);
    if (size == 2'd0) begin
      v = v & 32'hFF;
      if (!uns && v >= 128) v = v - 32'd256;
    end else if (size == 2'd1) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32768) v = v - 32'd65536;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old, input int off,
                                          input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] mask;
    if (size == 2'd0)      mask = 32'hFF << (8 * off);
    else if (size == 2'd1) mask = 32'hFFFF << (8 * off);
    else                   mask = 32'hFFFF_FFFF;
    return (old & ~mask) | ((wd << (8 * off)) & mask);
  endfunction

  task automatic accept(input int port);
    req_t r;
    rsp_t e;
    wr_t  w;
    r = (port == 0) ? cur0 : cur1;
    e.due = cyc + 2; e.port = port; e.rdata = '0; e.err = m_err(r.addr, r.size);
    if (!e.err) begin
      if (r.we) begin
        w.due  = cyc + 1;
        w.word = r.addr / 4;
        w.data = m_merge(ref_mem[w.word[9:0]], int'(r.addr % 4), r.size, r.wdata);
        wr_q.push_back(w);
      end else begin
        e.rdata = m_load(ref_mem[(r.addr / 4) % 1024], int'(r.addr % 4), r.size, r.uns);
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic present(input int i, input req_t r);
    rq_valid[i]         = 1'b1;
    rq_we[i]            = r.we;
    rq_unsigned[i]      = r.uns;
    rq_size[i*2 +: 2]   = r.size;
    rq_addr[i*32 +: 32] = r.addr;
    rq_wdata[i*32 +: 32] = r.wdata;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Drivers: hold a request until its handshake, then present the next one.
  always @(posedge clk) begin
    #1;
    if (hs_flag[0]) begin hs_flag[0] = 1'b0; rq_valid[0] = 1'b0; end
    if (hs_flag[1]) begin hs_flag[1] = 1'b0; rq_valid[1] = 1'b0; end
    if (rst_n && !rq_valid[0] && pend0.size() > 0) begin
      cur0 = pend0.pop_front(); present(0, cur0);
    end
    if (rst_n && !rq_valid[1] && pend1.size() > 0) begin
      cur1 = pend1.pop_front(); present(1, cur1);
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin : mon
    logic exp_we;
    rsp_t r;
    if (!rst_n) begin
      exp_q.delete();
      wr_q.delete();
      hs_flag = 2'b00;
    end else begin
      exp_we = (wr_q.size() > 0) && (wr_q[0].due == cyc);
      check("mem_we", 32'(mem_we), 32'(exp_we));
      if (exp_we) begin
        check("mem_a", mem_a, wr_q[0].word);
        check("mem_wd", mem_wd, wr_q[0].data);
        ref_mem[wr_q[0].word[9:0]] = wr_q[0].data;
        void'(wr_q.pop_front());
      end
      if (mem_we) begin we_count++; last_mem_a = mem_a; end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        r = exp_q.pop_front();
        check("rsp_valid", 32'(rsp_valid), (r.port == 1) ? 32'd2 : 32'd1);
        check("rsp_rdata", rsp_rdata, r.rdata);
        check("rsp_err", 32'(rsp_err), 32'(r.err));
        rsp_log.push_back(rsp_rdata);
        err_log.push_back(rsp_err);
      end else begin
        check("rsp_valid_quiet", 32'(rsp_valid), 32'd0);
      end
      check("ready_onehot", 32'($countones(rq_ready) <= 1), 32'd1);
      for (int i = 0; i < 2; i++) begin
        if (rq_valid[i] && rq_ready[i]) begin
          accept(i);
          hs_flag[i] = 1'b1;
          hs_port.push_back(i);
          hs_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((pend0.size() > 0 || pend1.size() > 0 || rq_valid != 2'b00 ||
            exp_q.size() > 0 || wr_q.size() > 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < 300), 32'd1);
    @(negedge clk);
  endtask

  task automatic clear_logs();
    hs_port.delete(); hs_cyc.delete(); rsp_log.delete(); err_log.delete();
  endtask

  initial begin
    int w0;
    int n;
    nvec = 0; nerr = 0; cyc = 0; we_count = 0; last_mem_a = '0; hs_flag = 2'b00;
    for (int i = 0; i < 1024; i++) begin dmem[i] = '0; ref_mem[i] = '0; end
    rq_valid = '0; rq_we = '0; rq_unsigned = '0; rq_addr = '0; rq_size = '0; rq_wdata = '0;
    rst_n = 1'b0;

    // Reset state, with a request pending that must not be accepted.
    repeat (3) @(negedge clk);
    rq_valid = 2'b01;
    #1;
    check("reset_rq_ready", 32'(rq_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    rq_valid = 2'b00;
    @(negedge clk) rst_n = 1'b1;

    // Word store then word load.
    clear_logs(); w0 = we_count;
    pend0.push_back(mk(1'b1, 32'h40, 2'd2, 1'b0, 32'hDEAD_BEEF));
    pend0.push_back(mk(1'b0, 32'h40, 2'd2, 1'b0, 32'h0));
    wait_drain("t1_drain");
    check("t1_we_pulses", 32'(we_count - w0), 32'd1);
    check("t1_mem_a", last_mem_a, 32'h10);
    check("t1_load", rsp_log[1], 32'hDEAD_BEEF);
    check("t1_err", 32'(err_log[1]), 32'd0);
    check("t1_hs_spacing", hs_cyc[1] - hs_cyc[0], 32'd2);

    // Sub-word store and extended loads.
    clear_logs();
    pend0.push_back(mk(1'b1, 32'h41, 2'd0, 1'b0, 32'h12));
    pend0.push_back(mk(1'b0, 32'h41, 2'd0, 1'b0, 32'h0));
    pend0.push_back(mk(1'b0, 32'h43, 2'd0, 1'b1, 32'h0));
    pend0.push_back(mk(1'b0, 32'h42, 2'd1, 1'b0, 32'h0));
    wait_drain("t2_drain");
    check("t2_word", dmem[16], 32'hDEAD_12EF);
    check("t2_sb_rdata", rsp_log[0], 32'h0);
    check("t2_lb", rsp_log[1], 32'h0000_0012);
    check("t2_lbu", rsp_log[2], 32'h0000_00DE);
    check("t2_lh", rsp_log[3], 32'hFFFF_DEAD);

    // Round-robin with both ports continuously requesting, from reset.
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    clear_logs();
    for (int k = 0; k < 3; k++) begin
      pend0.push_back(mk(1'b0, 32'h40, 2'd2, 1'b0, 32'h0));
      pend1.push_back(mk(1'b0, 32'h40 + 32'(k), 2'd0, 1'b1, 32'h0));
    end
    wait_drain("t3_drain");
    check("t3_hs_count", 32'(hs_port.size()), 32'd6);
    for (int k = 0; k < 6; k++) check("t3_grant_order", 32'(hs_port[k]), 32'(k % 2));
    for (int k = 1; k < 6; k++) check("t3_hs_spacing", hs_cyc[k] - hs_cyc[k-1], 32'd2);

    // Error cases: no write, zero data, err set.
    clear_logs(); w0 = we_count;
    pend0.push_back(mk(1'b0, 32'h41, 2'd1, 1'b0, 32'h0));
    pend0.push_back(mk(1'b1, 32'h42, 2'd2, 1'b0, 32'h1111_1111));
    pend0.push_back(mk(1'b0, 32'h40, 2'd3, 1'b0, 32'h0));
    pend0.push_back(mk(1'b0, 32'h8_0000, 2'd2, 1'b0, 32'h0));
    wait_drain("t4_drain");
    for (int k = 0; k < 4; k++) begin
      check("t4_err", 32'(err_log[k]), 32'd1);
      check("t4_rdata", rsp_log[k], 32'd0);
    end
    check("t4_no_write", 32'(we_count - w0), 32'd0);

    // Reset while a store is in its memory cycle.
    clear_logs();
    pend0.push_back(mk(1'b1, 32'h80, 2'd2, 1'b0, 32'h55));
    n = 0;
    while (hs_port.size() == 0 && n < 50) begin @(negedge clk); #1; n++; end
    check("t5_hs_seen", 32'(n < 50), 32'd1);
    @(posedge clk); #2;
    check("t5_we_in_access", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_we_dropped", 32'(mem_we), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("t5_no_rsp", 32'(rsp_valid), 32'd0);
    end
    check("t5_word_unchanged", dmem[32], 32'h0);
    rst_n = 1'b1;
    clear_logs();
    pend0.push_back(mk(1'b0, 32'h80, 2'd2, 1'b0, 32'h0));
    pend1.push_back(mk(1'b0, 32'h80, 2'd2, 1'b0, 32'h0));
    wait_drain("t5_drain");
    check("t5_first_grant", 32'(hs_port[0]), 32'd0);
    check("t5_second_grant", 32'(hs_port[1]), 32'd1);
    check("t5_load_zero", rsp_log[0], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
- Single-owner controller in front of the word-addressed data memory (one clock, synchronous write, combinational read).
- Shares the memory between two byte-addressed requesters: port 0 is the CPU load/store unit, port 1 is the loader/debug port.
- Provides round-robin arbitration, byte/half/word access with sign/zero extension, read-modify-write for sub-word stores, and misalignment/range checking.

Parameters:
- ADDRESS_WIDTH, 32, byte-address width of requesters and width of mem_a.
- DATA_WIDTH, 32, data width. Only 32 is supported; elaboration fails otherwise.
- MEM_WORDS, 32'h20000, number of words in the memory; sets the legal address range.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rq_valid  in  2  request valid, bit i = port i
- rq_ready  out  2  request accepted when valid&ready
- rq_we  in  2  1 = store, 0 = load (per port)
- rq_addr  in  2xADDRESS_WIDTH  byte address per port
- rq_size  in  2x2  0 byte, 1 half, 2 word, 3 illegal
- rq_unsigned  in  2  loads: 1 zero-extend, 0 sign-extend
- rq_wdata  in  2xDATA_WIDTH  store data, LSB-aligned
- rsp_valid  out  2  one-cycle response pulse to the owning port
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal size, or out of range
- mem_we  out  1  memory write enable
- mem_a  out  ADDRESS_WIDTH  word address = latched byte address >> 2
- mem_wd  out  DATA_WIDTH  merged write word
- mem_rd  in  DATA_WIDTH  combinational read data

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=1, all latched request registers 0.
  - rq_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - mem_we=0 immediately, because mem_we is decoded from state. A store caught in ACCESS is dropped with no partial write.
- Arbitration:
  - Only in IDLE or RESP.
  - One valid request: grant it.
  - Both valid: grant the port != last_grant.
  - rq_ready is one-hot to the winner; at most one bit is set per cycle.
  - On handshake: latch port id, we, addr, size, unsigned, wdata; update last_grant; go to ACCESS.
  - rq_valid with no handshake: state unchanged. Requesters must hold the request until ready.
- ACCESS (exactly one cycle):
  - mem_a = addr[ADDRESS_WIDTH-1:2].
  - Error when any of the following holds:
    - size=3;
    - size=1 and addr[0]=1;
    - size=2 and addr[1:0]!=0;
    - (addr>>2) >= MEM_WORDS.
    On error: mem_we=0, err flag set.
  - Legal load: capture the lane of mem_rd selected by addr[1:0], extended per size/unsigned, into rsp_rdata.
  - Legal store: mem_we=1. mem_wd = mem_rd with the selected byte or half lane replaced by wdata[7:0] or wdata[15:0]. A word store gives mem_wd = wdata. The write commits at the clock edge that ends ACCESS.
  - Always go to RESP.
- RESP:
  - rsp_valid[owner]=1 for exactly one cycle with registered rsp_rdata and rsp_err.
  - Simultaneous new grant allowed (pipelined arbitration).
  - Next state is ACCESS if a handshake occurs, else IDLE.
- Latency: handshake at cycle N, memory effect at the N+1 edge, rsp_valid in cycle N+2. Sustained throughput is one access per 2 cycles.
- Load-after-store to the same word sees the new data (the write commits before the next ACCESS).
- No outputs toggle in IDLE without requests; rsp_rdata holds its last value while rsp_valid=0.

Decomposition:
- Package datamem_arbiter_pkg:
  - size_t enum (SZ_B, SZ_H, SZ_W, SZ_BAD);
  - state_t enum (IDLE, ACCESS, RESP);
  - constant WORD_BYTES=4.
- Sub-module lane_align (combinational), used by both the ACCESS load and store paths:
  - inputs: offset[1:0], size, unsigned, old word, wdata;
  - outputs: merged write word, extended load data, misalign flag.

Test Plan:
- Port 0 stores word 0xDEADBEEF at 0x40, then loads a word from 0x40 → mem_we pulses once with mem_a=0x10; second rsp_rdata=0xDEADBEEF, rsp_err=0; each rsp_valid arrives 2 cycles after its handshake.
- With 0xDEADBEEF at 0x40: SB 0x12 to 0x41, then LB 0x41 signed, LBU 0x43, LH 0x42 signed → stored word 0xDEAD12EF; loads return 0x00000012, 0x000000DE, 0xFFFFDEAD.
- Both ports hold valid continuously for 6 accesses → grants alternate 0,1,0,1,0,1 (port 0 first after reset); each handshake is 2 cycles apart; rsp_valid goes only to the owner.
- Misaligned and range errors: LH 0x41, SW 0x42, size=3, LW 0x80000 → rsp_err=1, rsp_rdata=0, mem_we never asserted.
- Assert rst_n=0 during ACCESS of SW 0x55 to 0x80 → mem_we drops immediately; word 0x20 unchanged; no rsp_valid; after release, port 0 is granted first.
